// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage rv32i pipeline: tracks outstanding fetch and
// data-memory transactions, merges hazards and redirects into stage enables and flushes.
module pipeline_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_need,
    input  logic             dmem_resp,
    input  logic             load_use,
    input  logic             br_taken,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             id_ex_we,
    output logic             ex_mem_we,
    output logic             mem_wb_we,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             fbuf_we,
    output logic             fbuf_sel,
    output logic             dbuf_we,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       dbg_fetch_state,
    output logic [1:0]       dbg_data_state
);

    typedef enum logic [1:0] {I_IDLE = 2'd0, I_WAIT = 2'd1, I_HELD = 2'd2} fetch_state_t;
    typedef enum logic [1:0] {D_IDLE = 2'd0, D_WAIT = 2'd1, D_DONE = 2'd2} data_state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    fetch_state_t     r_fstate, w_fstate_next;
    data_state_t      r_dstate, w_dstate_next;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
    logic             w_imem_busy, w_dmem_busy, w_advance;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fstate <= I_IDLE;
            r_dstate <= D_IDLE;
        end else begin
            r_fstate <= w_fstate_next;
            r_dstate <= w_dstate_next;
        end
    end

    // Every output is forced low while rst is high, even though IDLE would request.
    always_comb begin
        w_imem_busy = (r_fstate == I_IDLE) || (r_fstate == I_WAIT && !imem_resp);
        w_dmem_busy = dmem_need && ((r_dstate == D_IDLE) || (r_dstate == D_WAIT && !dmem_resp));
        w_advance   = !rst && !(w_imem_busy || w_dmem_busy);
        pc_we       = w_advance && (br_taken || !load_use);
        if_id_we    = pc_we;
        id_ex_we    = w_advance;
        ex_mem_we   = w_advance;
        mem_wb_we   = w_advance;
        id_ex_flush = w_advance && (br_taken || load_use);
        if_id_flush = w_advance && br_taken;
    end

    always_comb begin
        w_fstate_next = r_fstate;
        imem_req      = 1'b0;
        fbuf_we       = 1'b0;
        fbuf_sel      = 1'b0;
        case (r_fstate)
            I_IDLE: begin
                imem_req      = 1'b1;
                w_fstate_next = I_WAIT;
            end
            I_WAIT: begin
                if (imem_resp) begin
                    if (pc_we) begin
                        imem_req = 1'b1;
                    end else begin
                        fbuf_we       = 1'b1;
                        w_fstate_next = I_HELD;
                    end
                end
            end
            I_HELD: begin
                fbuf_sel = 1'b1;
                if (pc_we) begin
                    imem_req      = 1'b1;
                    w_fstate_next = I_WAIT;
                end
            end
            default: w_fstate_next = I_IDLE;
        endcase
        if (rst) begin
            imem_req = 1'b0;
            fbuf_we  = 1'b0;
            fbuf_sel = 1'b0;
        end
    end

    // A completed access parks in D_DONE so the request is not reissued while frozen.
    always_comb begin
        w_dstate_next = r_dstate;
        dmem_req      = 1'b0;
        dbuf_we       = 1'b0;
        case (r_dstate)
            D_IDLE: begin
                if (dmem_need) begin
                    dmem_req      = 1'b1;
                    w_dstate_next = D_WAIT;
                end
            end
            D_WAIT: begin
                if (dmem_resp) begin
                    dbuf_we       = 1'b1;
                    w_dstate_next = w_advance ? D_IDLE : D_DONE;
                end
            end
            D_DONE: begin
                if (w_advance) w_dstate_next = D_IDLE;
            end
            default: w_dstate_next = D_IDLE;
        endcase
        if (rst) begin
            dmem_req = 1'b0;
            dbuf_we  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_we && r_stall_cnt != '1) r_stall_cnt <= r_stall_cnt + CNT_ONE;
            if (if_id_flush && r_flush_cnt != '1) r_flush_cnt <= r_flush_cnt + CNT_ONE;
        end
    end

    assign stall_cnt       = r_stall_cnt;
    assign flush_cnt       = r_flush_cnt;
    assign dbg_fetch_state = r_fstate;
    assign dbg_data_state  = r_dstate;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed plus randomized checks of pipeline_ctrl against a transaction-level model.
module tb_pipeline_ctrl;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst, imem_resp, dmem_need, dmem_resp, load_use, br_taken;
    logic imem_req, dmem_req, pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic if_id_flush, id_ex_flush, fbuf_we, fbuf_sel, dbuf_we;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic [1:0] dbg_fetch_state, dbg_data_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: fetch outstanding / instruction held, data access outstanding / data held.
    bit m_f_out, m_f_have, m_d_out, m_d_have;
    int m_stall, m_flush;
    bit e_adv, e_pc, e_idf, e_iff, e_ireq, e_fbw, e_fsel, e_dreq, e_dbw;

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .imem_resp(imem_resp), .dmem_need(dmem_need), .dmem_resp(dmem_resp),
        .load_use(load_use), .br_taken(br_taken),
        .imem_req(imem_req), .dmem_req(dmem_req), .pc_we(pc_we), .if_id_we(if_id_we),
        .id_ex_we(id_ex_we), .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .fbuf_we(fbuf_we), .fbuf_sel(fbuf_sel), .dbuf_we(dbuf_we),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .dbg_fetch_state(dbg_fetch_state), .dbg_data_state(dbg_data_state)
    );

    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chkc(input string tag, input logic [CNT_W-1:0] obs, input int exp);
        n_tests++;
        assert (obs === CNT_W'(exp)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_eval();
        bit f_idle, d_idle, ibusy, dbusy;
        f_idle = !m_f_out && !m_f_have;
        d_idle = !m_d_out && !m_d_have;
        ibusy  = f_idle || (m_f_out && !imem_resp);
        dbusy  = dmem_need && (d_idle || (m_d_out && !dmem_resp));
        e_adv  = !(ibusy || dbusy);
        e_pc   = e_adv && (br_taken || !load_use);
        e_idf  = e_adv && (br_taken || load_use);
        e_iff  = e_adv && br_taken;
        e_ireq = f_idle || (m_f_out && imem_resp && e_pc) || (m_f_have && e_pc);
        e_fbw  = m_f_out && imem_resp && !e_pc;
        e_fsel = m_f_have;
        e_dreq = d_idle && dmem_need;
        e_dbw  = m_d_out && dmem_resp;
    endtask

    task automatic model_update();
        if (!m_f_out && !m_f_have) m_f_out = 1'b1;
        else if (m_f_out && imem_resp && !e_pc) begin m_f_out = 1'b0; m_f_have = 1'b1; end
        else if (m_f_have && e_pc) begin m_f_have = 1'b0; m_f_out = 1'b1; end
        if (!m_d_out && !m_d_have && dmem_need) m_d_out = 1'b1;
        else if (m_d_out && dmem_resp) begin m_d_out = 1'b0; m_d_have = !e_adv; end
        else if (m_d_have && e_adv) m_d_have = 1'b0;
        if (!e_pc && m_stall < CNT_MAX) m_stall++;
        if (e_iff && m_flush < CNT_MAX) m_flush++;
    endtask

    task automatic check_all();
        chk1("imem_req", imem_req, e_ireq);
        chk1("dmem_req", dmem_req, e_dreq);
        chk1("pc_we", pc_we, e_pc);
        chk1("if_id_we", if_id_we, e_pc);
        chk1("id_ex_we", id_ex_we, e_adv);
        chk1("ex_mem_we", ex_mem_we, e_adv);
        chk1("mem_wb_we", mem_wb_we, e_adv);
        chk1("if_id_flush", if_id_flush, e_iff);
        chk1("id_ex_flush", id_ex_flush, e_idf);
        chk1("fbuf_we", fbuf_we, e_fbw);
        chk1("fbuf_sel", fbuf_sel, e_fsel);
        chk1("dbuf_we", dbuf_we, e_dbw);
        chkc("stall_cnt", stall_cnt, m_stall);
        chkc("flush_cnt", flush_cnt, m_flush);
    endtask

    task automatic check_zero(input string tag);
        logic any_out;
        any_out = imem_req | dmem_req | pc_we | if_id_we | id_ex_we | ex_mem_we | mem_wb_we |
                  if_id_flush | id_ex_flush | fbuf_we | fbuf_sel | dbuf_we;
        chk1({tag, "_outputs"}, any_out, 1'b0);
        chkc({tag, "_stall_cnt"}, stall_cnt, 0);
        chkc({tag, "_flush_cnt"}, flush_cnt, 0);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic step(input bit ir, input bit dn, input bit dr, input bit lu, input bit bt);
        imem_resp = ir; dmem_need = dn; dmem_resp = dr; load_use = lu; br_taken = bt;
        #1;
        model_eval();
        check_all();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic reset_pulse();
        rst = 1'b1;
        imem_resp = 1'b1; dmem_need = 1'b1; dmem_resp = 1'b1; load_use = 1'b0; br_taken = 1'b1;
        #1;
        check_zero("rst_assert");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_zero("rst_held");
        end
        @(negedge clk);
        rst = 1'b0;
        m_f_out = 0; m_f_have = 0; m_d_out = 0; m_d_have = 0;
        m_stall = 0; m_flush = 0;
    endtask

    initial begin
        rst = 1'b1;
        imem_resp = 0; dmem_need = 0; dmem_resp = 0; load_use = 0; br_taken = 0;
        @(negedge clk);
        reset_pulse();

        // Boot: fetch every cycle, one stall for the first request.
        step(0, 0, 0, 0, 0);
        chk1("boot_pc_we_cycle0", pc_we, 1'b0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0);
        chkc("boot_stall_cnt", stall_cnt, 1);

        // Load-use bubble with the fetch landing in the hold buffer.
        step(1, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        chkc("load_use_stall_cnt", stall_cnt, 2);
        step(1, 0, 0, 0, 0);

        // Branch beats load-use.
        step(1, 0, 0, 1, 1);
        chkc("branch_flush_cnt", flush_cnt, 1);

        // Slow data access; fetch response arrives while frozen.
        step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);

        // Data completes first, fetch still outstanding.
        step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);

        // Reset while data waits and fetch is held; stale responses after release.
        step(1, 1, 0, 0, 0);
        reset_pulse();
        step(1, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0);

        // Random traffic, long enough to drive both counters into saturation.
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0);
        end
        chkc("stall_saturated", stall_cnt, CNT_MAX);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
